// File: rtl/dct_block_packer.sv
// rtl/dct_block_packer.sv - packs a raster pixel stream into 8x8 DCT blocks through a ping-pong buffer.
// Optional: define PACK_LEVEL_SHIFT_EN to subtract 2^(PIX_W-1) from each pixel before scaling.
module dct_block_packer #(
  parameter int PIX_W         = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int FRAC_BITS     = 16,
  parameter int WORDS_PER_BLK = 64,
  parameter int BLK_IDX_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [PIX_W-1:0]           s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [64*DATA_WIDTH-1:0]   m_data,
  output logic [BLK_IDX_W-1:0]       m_blk_idx,
  output logic                       busy
);

  localparam int CNT_W = 6;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} bank_state_t;

  generate
    if (WORDS_PER_BLK != 64) begin : g_bad_words_per_blk
      $error("dct_block_packer: WORDS_PER_BLK must be 64");
    end
  endgenerate

  bank_state_t            bank_st_q [2];
  bank_state_t            bank_st_d [2];
  logic [DATA_WIDTH-1:0]  bank_data [2][WORDS_PER_BLK];
  logic [BLK_IDX_W-1:0]   bank_tag  [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [CNT_W-1:0]       wr_cnt;
  logic [BLK_IDX_W-1:0]   blk_cnt;

  logic                   s_fire;
  logic                   m_fire;
  logic                   last_word;
  logic [DATA_WIDTH-1:0]  pix_ext;
  logic [DATA_WIDTH-1:0]  pix_word;

  // Pixel to fixed point: integer part lands at bit FRAC_BITS.
`ifdef PACK_LEVEL_SHIFT_EN
  logic [PIX_W:0] pix_centred;
  assign pix_centred = {1'b0, s_data} - {2'b01, {(PIX_W-1){1'b0}}};
  assign pix_ext     = {{(DATA_WIDTH-PIX_W-1){pix_centred[PIX_W]}}, pix_centred};
`else
  assign pix_ext     = {{(DATA_WIDTH-PIX_W){1'b0}}, s_data};
`endif
  assign pix_word = pix_ext << FRAC_BITS;

  // Handshake flags come only from registered bank state, never from s_valid.
  assign s_ready   = (bank_st_q[wr_ptr] == EMPTY);
  assign m_valid   = (bank_st_q[rd_ptr] == FULL);
  assign s_fire    = s_valid && s_ready;
  assign m_fire    = m_valid && m_ready;
  assign last_word = (wr_cnt == CNT_W'(WORDS_PER_BLK - 1));
  assign m_blk_idx = bank_tag[rd_ptr];
  assign busy      = (bank_st_q[0] == FULL) || (bank_st_q[1] == FULL) || (wr_cnt != '0);

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_m_data
      assign m_data[gi*DATA_WIDTH +: DATA_WIDTH] = bank_data[rd_ptr][gi];
    end
  endgenerate

  // The filling bank is always EMPTY and the presented bank FULL, so a
  // completion and a consumption in the same cycle never touch the same bank.
  always_comb begin
    bank_st_d[0] = bank_st_q[0];
    bank_st_d[1] = bank_st_q[1];
    if (m_fire) begin
      bank_st_d[rd_ptr] = EMPTY;
    end
    if (s_fire && last_word) begin
      bank_st_d[wr_ptr] = FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_st_q[0] <= EMPTY;
      bank_st_q[1] <= EMPTY;
      bank_tag[0]  <= '0;
      bank_tag[1]  <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      wr_cnt       <= '0;
      blk_cnt      <= '0;
    end else begin
      bank_st_q[0] <= bank_st_d[0];
      bank_st_q[1] <= bank_st_d[1];
      if (s_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (last_word) begin
          bank_tag[wr_ptr] <= blk_cnt;
          blk_cnt          <= blk_cnt + 1'b1;
          wr_ptr           <= ~wr_ptr;
        end
      end
      if (m_fire) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Payload needs no reset; a bank is only presented after all 64 words are rewritten.
  always_ff @(posedge clk) begin
    if (s_fire) begin
      bank_data[wr_ptr][wr_cnt] <= pix_word;
    end
  end

endmodule

// File: tb/tb_dct_block_packer.sv
// tb/tb_dct_block_packer.sv - directed self-checking bench for dct_block_packer.
module tb_dct_block_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [7:0]   s_data;
  logic         m_valid;
  logic         m_ready;
  logic [2047:0] m_data;
  logic [1:0]   m_blk_idx;
  logic         busy;

  always #5 clk = ~clk;

  dct_block_packer #(.BLK_IDX_W(2)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_blk_idx(m_blk_idx), .busy(busy)
  );

`ifdef PACK_LEVEL_SHIFT_EN
  localparam logic [31:0] W_PIX00 = 32'hFF800000;
  localparam logic [31:0] W_PIX3F = 32'hFFBF0000;
  localparam logic [31:0] W_PIXFF = 32'h007F0000;
`else
  localparam logic [31:0] W_PIX00 = 32'h00000000;
  localparam logic [31:0] W_PIX3F = 32'h003F0000;
  localparam logic [31:0] W_PIXFF = 32'h00FF0000;
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] conv(input logic [7:0] p);
`ifdef PACK_LEVEL_SHIFT_EN
    int v;
    v = int'(p) - 128;
    return 32'(v * 65536);
`else
    return {8'h00, p, 16'h0000};
`endif
  endfunction

  // Scoreboard: partial block pixels, complete blocks awaiting transfer.
  logic [7:0]    pix_q [$];
  logic [2047:0] blk_q [$];
  logic [1:0]    idx_q [$];
  logic [1:0]    exp_idx = '0;
  bit            mon_en = 1'b0;
  int            cyc = 0;
  int            xfer_cnt = 0;
  int            acc_cnt = 0;
  int            stall_cnt = 0;
  int            xfer_cyc [$];
  logic [1:0]    idx_log [$];
  logic [2047:0] last_blk;
  logic [1:0]    last_idx;

  always @(negedge clk) begin
    logic [2047:0] hb;
    logic [2047:0] nb;
    int bad;
    cyc++;
    if (mon_en) begin
      check("m_valid", 32'(m_valid), 32'(blk_q.size() != 0));
      check("s_ready", 32'(s_ready), 32'(blk_q.size() < 2));
      check("busy", 32'(busy), 32'((blk_q.size() != 0) || (pix_q.size() != 0)));
      if (m_valid && blk_q.size() != 0) begin
        hb  = blk_q[0];
        bad = 0;
        for (int i = 63; i >= 0; i--) begin
          if (m_data[i*32 +: 32] !== hb[i*32 +: 32]) bad = i;
        end
        check("m_word", m_data[bad*32 +: 32], hb[bad*32 +: 32]);
        check("m_blk_idx", 32'(m_blk_idx), 32'(idx_q[0]));
      end
      if (rst) begin
        pix_q.delete();
        blk_q.delete();
        idx_q.delete();
        exp_idx = '0;
      end else begin
        if (m_valid && m_ready && blk_q.size() != 0) begin
          last_blk = blk_q.pop_front();
          last_idx = idx_q.pop_front();
          idx_log.push_back(m_blk_idx);
          xfer_cyc.push_back(cyc);
          xfer_cnt++;
        end
        if (s_valid && !s_ready) stall_cnt++;
        if (s_valid && s_ready) begin
          acc_cnt++;
          pix_q.push_back(s_data);
          if (pix_q.size() == 64) begin
            for (int i = 0; i < 64; i++) nb[i*32 +: 32] = conv(pix_q[i]);
            blk_q.push_back(nb);
            idx_q.push_back(exp_idx);
            exp_idx = exp_idx + 2'd1;
            pix_q.delete();
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    xfer_cnt  = 0;
    acc_cnt   = 0;
    stall_cnt = 0;
    xfer_cyc.delete();
    idx_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    clear_stats();
  endtask

  task automatic send_pix(input logic [7:0] d, input bit gappy);
    int budget;
    bit fired;
    budget = 0;
    if (gappy) begin
      while ($urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        step();
      end
    end
    s_valid = 1'b1;
    s_data  = d;
    forever begin
      @(negedge clk);
      fired = s_ready;
      @(posedge clk);
      #1;
      if (fired) break;
      budget++;
      if (budget > 2000) begin
        check("s_timeout", 32'd1, 32'd0);
        $fatal(1, "input stalled");
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while ((busy || m_valid) && budget < 1000) begin
      step();
      budget++;
    end
    check("idle_timeout", 32'(budget >= 1000), 32'd0);
  endtask

  logic [1:0] exp_wrap [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  bit gap_done;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    step();
    do_reset();
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_blk_idx", 32'(m_blk_idx), 32'd0);
    mon_en = 1'b1;

    // Single block 0..63
    m_ready = 1'b1;
    for (int i = 0; i < 64; i++) send_pix(8'(i), 1'b0);
    check("t1_latency", 32'(m_valid), 32'd1);
    check("t1_word0", m_data[31:0], W_PIX00);
    check("t1_word63", m_data[63*32 +: 32], W_PIX3F);
    check("t1_idx", 32'(m_blk_idx), 32'd0);
    wait_idle();
    check("t1_nblk", 32'(xfer_cnt), 32'd1);

    // Backpressure: 192 pixels with m_ready held low
    do_reset();
    m_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 192; i++) send_pix(8'((i * 7 + 3) & 8'hFF), 1'b0);
      end
      begin
        for (int k = 0; k < 1000 && acc_cnt < 128; k++) step();
        repeat (5) step();
        check("bp_s_ready", 32'(s_ready), 32'd0);
        check("bp_m_valid", 32'(m_valid), 32'd1);
        check("bp_acc", 32'(acc_cnt), 32'd128);
        m_ready = 1'b1;
      end
    join
    wait_idle();
    check("bp_nblk", 32'(xfer_cnt), 32'd3);
    for (int i = 0; i < 3 && i < idx_log.size(); i++) check("bp_idx", 32'(idx_log[i]), 32'(i));

    // Throughput: 10 back-to-back blocks
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 640; i++) send_pix(8'(i ^ (i >> 3)), 1'b0);
    wait_idle();
    check("tp_stalls", 32'(stall_cnt), 32'd0);
    check("tp_nblk", 32'(xfer_cnt), 32'd10);
    for (int i = 1; i < xfer_cyc.size(); i++) check("tp_spacing", 32'(xfer_cyc[i] - xfer_cyc[i-1]), 32'd64);

    // Gappy input with random m_ready
    do_reset();
    gap_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 256; i++) send_pix(8'($urandom_range(0, 255)), 1'b1);
        gap_done = 1'b1;
      end
      begin
        while (!gap_done) begin
          m_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    m_ready = 1'b1;
    wait_idle();
    check("gap_nblk", 32'(xfer_cnt), 32'd4);

    // Reset after 30 pixels, then a block of 0xFF
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 30; i++) send_pix(8'h10, 1'b0);
    do_reset();
    check("mid_busy", 32'(busy), 32'd0);
    m_ready = 1'b1;
    for (int i = 0; i < 64; i++) send_pix(8'hFF, 1'b0);
    wait_idle();
    check("mid_nblk", 32'(xfer_cnt), 32'd1);
    check("mid_word0", last_blk[31:0], W_PIXFF);
    check("mid_word29", last_blk[29*32 +: 32], W_PIXFF);
    check("mid_word63", last_blk[63*32 +: 32], W_PIXFF);
    check("mid_idx", 32'(last_idx), 32'd0);

    // Block counter wrap with a 2-bit index
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 320; i++) send_pix(8'(i), 1'b0);
    wait_idle();
    check("wrap_nblk", 32'(xfer_cnt), 32'd5);
    for (int i = 0; i < 5 && i < idx_log.size(); i++) check("wrap_idx", 32'(idx_log[i]), 32'(exp_wrap[i]));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dct_block_packer.md
Name: dct_block_packer

Overview:
- Transmitter side of the 2-D 8x8 DCT block interface.
- Accepts a serial stream of unsigned 8-bit pixels in raster order within one 8x8 block (row 0 col 0 first).
- Converts each pixel to a signed fixed-point word and assembles 64 words into one wide block.
- Presents each block on the DCT core's block-level valid/ready input through a two-entry ping-pong buffer, so pixel intake continues while the DCT holds a block.

Parameters:
- PIX_W, 8: input pixel width, unsigned.
- DATA_WIDTH, 32: output word width, signed two's complement.
- FRAC_BITS, 16: fraction bits of the output word; pixel integer part placed at bit FRAC_BITS.
- WORDS_PER_BLK, 64: words per block; fixed at 64, elaboration error otherwise.
- BLK_IDX_W, 16: width of the block sequence counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  pixel valid.
- s_ready  out  1  packer can accept a pixel this cycle.
- s_data  in  PIX_W  unsigned pixel.
- m_valid  out  1  block valid; connects to the DCT core's in_valid.
- m_ready  in  1  connects to the DCT core's in_ready.
- m_data  out  64*DATA_WIDTH  block; word i at [i*DATA_WIDTH +: DATA_WIDTH], i = row*8+col, row-major.
- m_blk_idx  out  BLK_IDX_W  sequence number of the block on m_data.
- busy  out  1  any buffer non-empty or a fill in progress.

Behaviour:
- Reset: synchronous, active-high; clk is the only clock.
  - On reset: both buffers EMPTY, wr_ptr=0, wr_cnt=0, rd_ptr=0, blk counter=0.
  - Output values after reset: m_valid=0, s_ready=1, busy=0, m_blk_idx=0.
  - m_data contents after reset are don't-care; the bench must not check them while m_valid=0.
- Buffers: two 64-word banks, each EMPTY or FULL.
  - wr_ptr selects the filling bank; rd_ptr selects the presented bank.
- Input handshake: a pixel transfers when s_valid && s_ready.
  - s_ready = (bank[wr_ptr] is EMPTY), registered, with no combinational path from s_valid.
  - The accepted pixel is converted and written to bank[wr_ptr] at word wr_cnt, then wr_cnt increments.
  - When the pixel at wr_cnt=63 transfers: wr_cnt wraps to 0, bank[wr_ptr] becomes FULL, the bank is tagged with the current blk counter, the blk counter increments (wraps at 2^BLK_IDX_W), and wr_ptr toggles.
- Conversion: word = sign-extend(pixel - 2^(PIX_W-1)) << FRAC_BITS, truncated to DATA_WIDTH.
  - Example: pixel 0xFF gives 0x007F0000; pixel 0x00 gives 0xFF800000.
- Output handshake: m_valid = (bank[rd_ptr] is FULL).
  - m_data and m_blk_idx come from bank[rd_ptr] and are stable while m_valid && !m_ready.
  - A transfer occurs on m_valid && m_ready; then bank[rd_ptr] becomes EMPTY and rd_ptr toggles.
  - m_valid never drops without a transfer.
- Latency: the 64th pixel accepted at edge N gives m_valid=1 in the cycle after edge N, provided no older block is pending.
- Throughput: one pixel per cycle sustained, provided each block is taken within 64 cycles of becoming valid.
- Simultaneous events:
  - Completing the last word of a bank in the same cycle the other bank is consumed is legal; both state updates happen.
  - When both banks are FULL, s_ready=0 until a transfer; s_ready rises in the cycle after the m_ready transfer.
- Ordering: blocks leave in acceptance order; m_blk_idx is strictly sequential.
- Reset mid-operation: a partially filled bank and any FULL banks are discarded; no block is emitted after reset.
- busy = any bank FULL or wr_cnt != 0.

Optional Feature:
- Macro: PACK_LEVEL_SHIFT_EN.
- Defined: conversion as above; subtract 2^(PIX_W-1) before scaling (JPEG level shift).
- Undefined: word = zero-extend(pixel) << FRAC_BITS, no subtraction.
  - Example: 0xFF gives 0x00FF0000; 0x00 gives 0x00000000.
- Handshake, timing and ordering are identical in both builds.

Test Plan:
- Single block: stream pixels 0..63, m_ready=1.
  - Required: m_valid 1 cycle after the 64th accept; word 0 = 0xFF800000, word 63 = 0xFFBF0000; m_blk_idx=0; one block only.
- Backpressure: hold m_ready=0, stream 192 pixels continuously.
  - Required: s_ready drops after pixel 128 (two FULL banks).
  - Required: m_data stays stable; releasing m_ready gives blocks idx 0,1,2 in order with correct contents.
- Throughput: s_valid=1 every cycle for 10 blocks, m_ready=1.
  - Required: s_ready never deasserts; exactly 10 m_valid pulses, 64 cycles apart.
- Gappy input: s_valid toggles pseudo-randomly, m_ready random with 50% duty.
  - Required: all output words match the scoreboard; no block lost or duplicated.
- Reset mid-block: assert rst after 30 pixels, then stream a full block of 0xFF.
  - Required: the only block emitted has all words 0x007F0000 (0x00FF0000 without PACK_LEVEL_SHIFT_EN) and m_blk_idx=0.
- Counter wrap: BLK_IDX_W=2, send 5 blocks.
  - Required: m_blk_idx sequence 0,1,2,3,0.
